// File: rtl/macc_l1_cfu.sv
// CFU-L1 fixed-latency multiply-accumulate unit with per-state accumulators.
// Status encodings live in cfu_pkg, shared with the requester side.
package cfu_pkg;
    localparam int CFU_CFU_ID_W = 8;
    localparam int CFU_STATUS_W = 3;
    localparam logic [CFU_STATUS_W-1:0] CFU_OK            = 3'd0;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_CFU     = 3'd1;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_OP      = 3'd2;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_STATE   = 3'd3;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_OFFLINE = 3'd4;
    localparam logic [CFU_STATUS_W-1:0] CFU_ERROR_CUSTOM  = 3'd7;
endpackage

// Handshake: a request is taken on any enabled edge with req_valid=1 (no ready);
// resp_valid pulses for one enabled cycle CFU_LATENCY enabled cycles later and is
// always accepted by the requester. Status/data read as zero when resp_valid=0.
module macc_l1_cfu
    import cfu_pkg::*;
#(
    parameter int CFU_LATENCY   = 2,
    parameter int CFU_N_STATES  = 4,
    parameter int CFU_FUNC_ID_W = 10,
    parameter int CFU_DATA_W    = 32,
    localparam int CFU_STATE_W  = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     req_valid,
    input  logic [CFU_CFU_ID_W-1:0]  req_cfu,
    input  logic [CFU_STATE_W-1:0]   req_state,
    input  logic [CFU_FUNC_ID_W-1:0] req_func,
    input  logic [CFU_DATA_W-1:0]    req_data0,
    input  logic [CFU_DATA_W-1:0]    req_data1,
    output logic                     resp_valid,
    output logic [CFU_STATUS_W-1:0]  resp_status,
    output logic [CFU_DATA_W-1:0]    resp_data
);

    logic [CFU_DATA_W-1:0]   acc_q [CFU_N_STATES];
    logic [CFU_LATENCY-1:0]  vld_q;
    logic [CFU_STATUS_W-1:0] sts_q [CFU_LATENCY];
    logic [CFU_DATA_W-1:0]   dat_q [CFU_LATENCY];

    logic                    accept;
    logic                    op_ok;
    logic                    state_ok;
    logic [CFU_DATA_W-1:0]   acc_cur;
    logic [CFU_DATA_W-1:0]   prod;
    logic [CFU_DATA_W-1:0]   mac_sum;
    logic [CFU_STATUS_W-1:0] status_d;
    logic [CFU_DATA_W-1:0]   result_d;
    logic                    acc_wr_en;
    logic [CFU_DATA_W-1:0]   acc_wr_data;

    // The CFU id is routed by the requester; this unit answers to any id.
    logic unused_cfu;
    assign unused_cfu = ^req_cfu;

    assign accept   = clk_en && req_valid;
    assign op_ok    = (req_func[CFU_FUNC_ID_W-1:3] == '0) && (req_func[2:0] <= 3'd4);
    assign state_ok = int'(req_state) < CFU_N_STATES;

    always_comb begin
        acc_cur     = '0;
        prod        = req_data0 * req_data1;
        status_d    = CFU_OK;
        result_d    = '0;
        acc_wr_en   = 1'b0;
        acc_wr_data = '0;
        if (state_ok) begin
            acc_cur = acc_q[req_state];
        end
        mac_sum = acc_cur + prod;
        // Opcode errors win over state errors; neither touches an accumulator.
        if (!op_ok) begin
            status_d = CFU_ERROR_OP;
        end else if (!state_ok) begin
            status_d = CFU_ERROR_STATE;
        end else begin
            case (req_func[2:0])
                3'd0: result_d = prod;
                3'd1: begin
                    result_d    = mac_sum;
                    acc_wr_en   = 1'b1;
                    acc_wr_data = mac_sum;
                end
                3'd2: result_d = acc_cur;
                3'd3: begin
                    result_d    = acc_cur;
                    acc_wr_en   = 1'b1;
                    acc_wr_data = req_data0;
                end
                3'd4: begin
                    result_d    = acc_cur;
                    acc_wr_en   = 1'b1;
                    acc_wr_data = '0;
                end
                default: result_d = '0;
            endcase
        end
    end

    // Accumulators commit at the accept edge, so same-state MACs chain freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CFU_N_STATES; i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept && acc_wr_en) begin
            acc_q[req_state] <= acc_wr_data;
        end
    end

    // Stage payloads stay zero for empty slots, so outputs need no masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < CFU_LATENCY; i++) begin
                sts_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else if (clk_en) begin
            vld_q[0] <= accept;
            sts_q[0] <= accept ? status_d : '0;
            dat_q[0] <= accept ? result_d : '0;
            for (int i = 1; i < CFU_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                sts_q[i] <= sts_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign resp_valid  = vld_q[CFU_LATENCY-1];
    assign resp_status = sts_q[CFU_LATENCY-1];
    assign resp_data   = dat_q[CFU_LATENCY-1];

endmodule

// File: tb/tb_macc_l1_cfu.sv
// Directed + random bench for macc_l1_cfu with a cycle-tagged response scoreboard.
// Three states are used so that an out-of-range state index is expressible.
module tb_macc_l1_cfu;
    import cfu_pkg::*;

    localparam int LAT = 2;
    localparam int NS  = 3;
    localparam int FW  = 10;
    localparam int DW  = 32;
    localparam int SW  = 2;
    localparam int RW  = CFU_STATUS_W + DW;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clk_en = 1'b0;
    logic                    req_valid = 1'b0;
    logic [CFU_CFU_ID_W-1:0] req_cfu = '0;
    logic [SW-1:0]           req_state = '0;
    logic [FW-1:0]           req_func = '0;
    logic [DW-1:0]           req_data0 = '0;
    logic [DW-1:0]           req_data1 = '0;
    logic                    resp_valid;
    logic [CFU_STATUS_W-1:0] resp_status;
    logic [DW-1:0]           resp_data;

    int total = 0;
    int bad = 0;
    int en_edges = 0;
    logic [RW-1:0] exp_q[$];
    int due_q[$];
    logic [DW-1:0] m_acc [NS];

    always #5 clk = ~clk;

    macc_l1_cfu #(
        .CFU_LATENCY(LAT),
        .CFU_N_STATES(NS),
        .CFU_FUNC_ID_W(FW),
        .CFU_DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .req_valid(req_valid),
        .req_cfu(req_cfu),
        .req_state(req_state),
        .req_func(req_func),
        .req_data0(req_data0),
        .req_data1(req_data1),
        .resp_valid(resp_valid),
        .resp_status(resp_status),
        .resp_data(resp_data)
    );

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && clk_en) en_edges++;
    end

    // Model of one accepted request: computes the response and updates m_acc.
    task automatic model(input logic [SW-1:0] st, input logic [FW-1:0] fn,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] cur;
        logic [DW-1:0] p;
        logic [DW-1:0] r;
        logic [CFU_STATUS_W-1:0] s;
        p = a * b;
        r = '0;
        s = CFU_OK;
        if (fn[FW-1:3] != '0 || fn[2:0] > 3'd4) begin
            s = CFU_ERROR_OP;
        end else if (int'(st) >= NS) begin
            s = CFU_ERROR_STATE;
        end else begin
            cur = m_acc[st];
            case (fn[2:0])
                3'd0: r = p;
                3'd1: begin r = cur + p; m_acc[st] = cur + p; end
                3'd2: r = cur;
                3'd3: begin r = cur; m_acc[st] = a; end
                default: begin r = cur; m_acc[st] = '0; end
            endcase
        end
        exp_q.push_back({s, r});
        due_q.push_back(en_edges + LAT);
    endtask

    task automatic step(input logic v, input logic [SW-1:0] st, input logic [FW-1:0] fn,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic en);
        req_valid = v;
        req_state = st;
        req_func  = fn;
        req_data0 = a;
        req_data1 = b;
        req_cfu   = 8'($urandom_range(0, 255));
        clk_en    = en;
        if (v && en) model(st, fn, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b1);
    endtask

    // Every enabled cycle is either the due cycle of the oldest response or idle.
    always @(negedge clk) begin
        if (rst_n && clk_en) begin
            if (due_q.size() > 0 && due_q[0] == en_edges) begin
                logic [RW-1:0] e;
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                check("resp_valid", RW'(resp_valid), RW'(1));
                check("resp_payload", {resp_status, resp_data}, e);
            end else begin
                check("idle_valid", RW'(resp_valid), RW'(0));
                check("idle_payload", {resp_status, resp_data}, '0);
            end
        end
    end

    initial begin
        for (int i = 0; i < NS; i++) m_acc[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", RW'(resp_valid), RW'(0));
        check("rst_payload", {resp_status, resp_data}, '0);
        rst_n = 1'b1;

        // MUL 7*6
        step(1'b1, 2'd0, 10'h000, 32'd7, 32'd6, 1'b1);
        idle(3);

        // Chained MACs on state 1, then reads of states 1 and 0
        step(1'b1, 2'd1, 10'h001, 32'd3, 32'd4, 1'b1);
        step(1'b1, 2'd1, 10'h001, 32'd5, 32'd5, 1'b1);
        step(1'b1, 2'd1, 10'h002, 32'd0, 32'd0, 1'b1);
        step(1'b1, 2'd0, 10'h002, 32'd0, 32'd0, 1'b1);
        idle(2);

        // Wrap on state 2, then clear
        step(1'b1, 2'd2, 10'h003, 32'hFFFF_FFFF, 32'd0, 1'b1);
        step(1'b1, 2'd2, 10'h001, 32'd1, 32'd1, 1'b1);
        step(1'b1, 2'd2, 10'h004, 32'd9, 32'd9, 1'b1);
        step(1'b1, 2'd2, 10'h002, 32'd0, 32'd0, 1'b1);

        // Error cases, including opcode-over-state precedence
        step(1'b1, 2'd1, 10'h008, 32'd2, 32'd2, 1'b1);
        step(1'b1, 2'd3, 10'h001, 32'd2, 32'd2, 1'b1);
        step(1'b1, 2'd3, 10'h009, 32'd2, 32'd2, 1'b1);
        step(1'b1, 2'd1, 10'h005, 32'd2, 32'd2, 1'b1);
        step(1'b1, 2'd1, 10'h002, 32'd0, 32'd0, 1'b1);
        idle(2);

        // Freeze mid-flight; requests while frozen must be ignored
        step(1'b1, 2'd0, 10'h001, 32'd2, 32'd3, 1'b1);
        step(1'b1, 2'd0, 10'h001, 32'd100, 32'd100, 1'b0);
        check("frozen_valid", RW'(resp_valid), RW'(0));
        step(1'b1, 2'd0, 10'h003, 32'd55, 32'd0, 1'b0);
        step(1'b1, 2'd1, 10'h004, 32'd0, 32'd0, 1'b0);
        idle(3);
        step(1'b1, 2'd0, 10'h002, 32'd0, 32'd0, 1'b1);
        step(1'b1, 2'd1, 10'h002, 32'd0, 32'd0, 1'b1);
        idle(2);

        // Random traffic with occasional freezes
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), SW'($urandom_range(0, 3)),
                 FW'($urandom_range(0, 9)), $urandom(), 32'($urandom_range(0, 15)),
                 1'($urandom_range(0, 4) != 0));
        end
        idle(3);

        // Asynchronous reset with two responses in flight
        step(1'b1, 2'd1, 10'h001, 32'd4, 32'd4, 1'b1);
        step(1'b1, 2'd2, 10'h001, 32'd6, 32'd6, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        for (int i = 0; i < NS; i++) m_acc[i] = '0;
        #1;
        check("async_rst_valid", RW'(resp_valid), RW'(0));
        check("async_rst_payload", {resp_status, resp_data}, '0);
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        step(1'b1, 2'd1, 10'h002, 32'd0, 32'd0, 1'b1);
        step(1'b1, 2'd2, 10'h002, 32'd0, 32'd0, 1'b1);
        idle(LAT + 2);

        check("drained", RW'(exp_q.size()), RW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
